// File: rtl/lbm_stream_gather.sv
// D2Q9 pull-streaming gather: walks the grid in raster order and presents the nine upstream
// populations of each cell. Define LBM_BOUNCE_BACK_EN for half-way bounce-back at the domain edge.
module lbm_stream_gather #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned HEIGHT        = 8,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 6
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [9*ADDRESS_WIDTH-1:0] o_rd_addr,
  input  logic [9*DATA_WIDTH-1:0]    i_rd_data,
  output logic [9*DATA_WIDTH-1:0]    o_out_f,
  output logic [ADDRESS_WIDTH-1:0]   o_out_index,
  output logic [8:0]                 o_out_missing,
  output logic                       o_out_valid,
  input  logic                       i_out_ready
);
  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] ColLast = CW'(WIDTH - 1);
  localparam logic [RW-1:0] RowLast = RW'(HEIGHT - 1);
  localparam logic [AW-1:0] IdxLast = AW'(WIDTH * HEIGHT - 1);
  localparam logic [AW-1:0] StepRow = AW'(WIDTH);
  localparam logic [AW-1:0] StepCol = AW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StCapture,
`ifdef LBM_BOUNCE_BACK_EN
    StIssueBb,
    StCaptureBb,
`endif
    StPresent,
    StDone
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [RW-1:0]   r_row, w_row_nxt;
  logic [CW-1:0]   r_col, w_col_nxt;
  logic [AW-1:0]   r_idx, w_idx_nxt;
  logic [9*AW-1:0] r_rd_addr, w_src_addr;
  logic [8:0]      r_missing, w_src_miss;
  logic [9*DW-1:0] r_f, w_cap_f;
  logic [AW-1:0]   w_cand [9];
  logic            w_handshake, w_last;
  logic            w_v_n, w_v_s, w_v_e, w_v_w;

  assign w_handshake = (r_state == StPresent) && i_out_ready;
  assign w_last      = (r_idx == IdxLast);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:    if (i_start) w_state_nxt = StIssue;
      StIssue:   w_state_nxt = StCapture;
      StCapture: begin
        w_state_nxt = StPresent;
`ifdef LBM_BOUNCE_BACK_EN
        if (r_missing != 9'd0) w_state_nxt = StIssueBb;
`endif
      end
`ifdef LBM_BOUNCE_BACK_EN
      StIssueBb:   w_state_nxt = StCaptureBb;
      StCaptureBb: w_state_nxt = StPresent;
`endif
      StPresent: if (i_out_ready) w_state_nxt = w_last ? StDone : StIssue;
      StDone:    w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
  end

  // Addresses are computed from the position the counters are about to take, so rd_addr is
  // already registered during ISSUE and the RAM data lands in CAPTURE.
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    w_idx_nxt = r_idx;
    if (r_state == StIdle && i_start) begin
      w_row_nxt = '0;
      w_col_nxt = '0;
      w_idx_nxt = '0;
    end else if (w_handshake && !w_last) begin
      w_idx_nxt = r_idx + StepCol;
      if (r_col == ColLast) begin
        w_col_nxt = '0;
        w_row_nxt = r_row + RW'(1);
      end else begin
        w_col_nxt = r_col + CW'(1);
      end
    end
  end

  assign w_v_n = (w_row_nxt < RowLast);
  assign w_v_s = (w_row_nxt != '0);
  assign w_v_e = (w_col_nxt != '0);
  assign w_v_w = (w_col_nxt < ColLast);

  assign w_cand[0] = w_idx_nxt;
  assign w_cand[1] = w_idx_nxt + StepRow;
  assign w_cand[2] = w_idx_nxt + StepRow - StepCol;
  assign w_cand[3] = w_idx_nxt - StepCol;
  assign w_cand[4] = w_idx_nxt - StepRow - StepCol;
  assign w_cand[5] = w_idx_nxt - StepRow;
  assign w_cand[6] = w_idx_nxt - StepRow + StepCol;
  assign w_cand[7] = w_idx_nxt + StepCol;
  assign w_cand[8] = w_idx_nxt + StepRow + StepCol;

  assign w_src_miss = ~{w_v_n & w_v_w, w_v_w, w_v_s & w_v_w, w_v_s, w_v_s & w_v_e,
                        w_v_e, w_v_n & w_v_e, w_v_n, 1'b1};

  always_comb begin
    w_src_addr = '0;
    for (int i = 0; i < 9; i++) begin
      if (!w_src_miss[i]) w_src_addr[i*AW +: AW] = w_cand[i];
    end
  end

  always_comb begin
    w_cap_f = '0;
    for (int i = 0; i < 9; i++) begin
      if (!r_missing[i]) w_cap_f[i*DW +: DW] = i_rd_data[i*DW +: DW];
    end
  end

`ifdef LBM_BOUNCE_BACK_EN
  logic [9*AW-1:0] w_bb_addr;
  logic [9*DW-1:0] w_bb_f;

  function automatic int unsigned opp(input int unsigned i);
    return (i == 0) ? 0 : ((i < 5) ? i + 4 : i - 4);
  endfunction

  // A missing slot reads the cell's own population travelling the opposite way.
  always_comb begin
    w_bb_addr = '0;
    w_bb_f    = r_f;
    for (int i = 1; i < 9; i++) begin
      if (r_missing[i]) begin
        w_bb_addr[opp(i)*AW +: AW] = r_idx;
        w_bb_f[i*DW +: DW]         = i_rd_data[opp(i)*DW +: DW];
      end
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_row     <= '0;
      r_col     <= '0;
      r_idx     <= '0;
      r_rd_addr <= '0;
      r_missing <= '0;
      r_f       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_idx   <= w_idx_nxt;
      if (w_state_nxt == StIssue) begin
        r_rd_addr <= w_src_addr;
        r_missing <= w_src_miss;
      end
`ifdef LBM_BOUNCE_BACK_EN
      if (w_state_nxt == StIssueBb) r_rd_addr <= w_bb_addr;
      if (r_state == StCaptureBb) r_f <= w_bb_f;
`endif
      if (r_state == StCapture) r_f <= w_cap_f;
    end
  end

  assign o_busy        = (r_state != StIdle);
  assign o_done        = (r_state == StDone);
  assign o_out_valid   = (r_state == StPresent);
  assign o_rd_addr     = r_rd_addr;
  assign o_out_f       = r_f;
  assign o_out_index   = r_idx;
  assign o_out_missing = r_missing;

endmodule

// File: tb/tb_lbm_stream_gather.sv
// Scoreboard bench for lbm_stream_gather on a 4x3 grid; RAM d at address a returns (d<<8)|a.
module tb_lbm_stream_gather;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 6;
  localparam int unsigned NC = W * H;
`ifdef LBM_BOUNCE_BACK_EN
  localparam int BB = 1;
`else
  localparam int BB = 0;
`endif

  logic            clk = 1'b0;
  logic            rst, start, ready;
  logic            busy, done, valid;
  logic [9*AW-1:0] rd_addr;
  logic [9*DW-1:0] rd_data;
  logic [9*DW-1:0] out_f;
  logic [AW-1:0]   out_index;
  logic [8:0]      out_missing;

  always #5 clk = ~clk;

  lbm_stream_gather #(
    .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
    .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_out_f(out_f), .o_out_index(out_index),
    .o_out_missing(out_missing), .o_out_valid(valid), .i_out_ready(ready)
  );

  // Synchronous-read RAM bank model.
  always @(posedge clk) begin
    for (int d = 0; d < 9; d++) begin
      rd_data[d*DW +: DW] <= DW'((d << 8) | int'(rd_addr[d*AW +: AW]));
    end
  end

  typedef struct packed {
    logic [AW-1:0]   idx;
    logic [9*DW-1:0] f;
    logic [8:0]      miss;
    logic [9*AW-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   last_pop = -1;
  int   exp_done, exp_first, edges;

  function automatic int opp(input int d);
    return (d == 0) ? 0 : ((d + 3) % 8) + 1;
  endfunction

  // Source = index - offset, offset given as (row, col) steps for C0,N,NE,E,SE,S,SW,W,NW.
  function automatic exp_t model(input int r, input int c);
    int   dr[9] = '{0, -1, -1, 0, 1, 1, 1, 0, -1};
    int   dc[9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
    exp_t e;
    int   x, sr, sc;
    x = r * int'(W) + c;
    e.idx = AW'(x);
    e.f = '0;
    e.miss = '0;
    e.addr = '0;
    for (int d = 0; d < 9; d++) begin
      sr = r - dr[d];
      sc = c - dc[d];
      if (sr >= 0 && sr < int'(H) && sc >= 0 && sc < int'(W)) begin
        e.f[d*DW +: DW]    = DW'((d << 8) | (sr * int'(W) + sc));
        e.addr[d*AW +: AW] = AW'(sr * int'(W) + sc);
      end else begin
        e.miss[d] = 1'b1;
        if (BB != 0) e.f[d*DW +: DW] = DW'((opp(d) << 8) | x);
      end
    end
    if (BB != 0 && e.miss != 9'd0) begin
      e.addr = '0;
      for (int d = 1; d < 9; d++) begin
        if (e.miss[opp(d)]) e.addr[d*AW +: AW] = AW'(x);
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int n);
    for (int c = 0; c < n; c++) sb.push_back(model(c / int'(W), c % int'(W)));
  endtask

  task automatic spot(input logic [AW-1:0] idx);
    if (idx == AW'(5)) begin
      chk("c5_N", 160'(out_f[1*DW +: DW]), 160'(16'h0109));
      chk("c5_E", 160'(out_f[3*DW +: DW]), 160'(16'h0304));
      chk("c5_S", 160'(out_f[5*DW +: DW]), 160'(16'h0501));
      chk("c5_NW", 160'(out_f[8*DW +: DW]), 160'(16'h080A));
    end
    if (idx == AW'(0)) begin
      chk("c0_N", 160'(out_f[1*DW +: DW]), 160'(16'h0104));
      chk("c0_W", 160'(out_f[7*DW +: DW]), 160'(16'h0701));
`ifdef LBM_BOUNCE_BACK_EN
      chk("c0_S", 160'(out_f[5*DW +: DW]), 160'(16'h0100));
      chk("c0_E", 160'(out_f[3*DW +: DW]), 160'(16'h0700));
`else
      chk("c0_S", 160'(out_f[5*DW +: DW]), 160'(16'h0000));
      chk("c0_E", 160'(out_f[3*DW +: DW]), 160'(16'h0000));
`endif
    end
    if (idx == AW'(11)) chk("c11_missing", 160'(out_missing), 160'(9'b1_1100_0110));
  endtask

  // Check any handshake happening at the coming edge, then advance to the next falling edge.
  task automatic tick();
    exp_t e;
    if (valid === 1'b1 && ready === 1'b1) begin
      chk("sb_has_entry", 160'(sb.size() != 0), 160'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("index", 160'(out_index), 160'(e.idx));
        chk("out_f", 160'(out_f), 160'(e.f));
        chk("missing", 160'(out_missing), 160'(e.miss));
        chk("rd_addr", 160'(rd_addr), 160'(e.addr));
        spot(e.idx);
        last_pop = int'(e.idx);
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_zero();
    chk("rst_busy", 160'(busy), 160'd0);
    chk("rst_done", 160'(done), 160'd0);
    chk("rst_valid", 160'(valid), 160'd0);
    chk("rst_rd_addr", 160'(rd_addr), 160'd0);
    chk("rst_out_f", 160'(out_f), 160'd0);
    chk("rst_index", 160'(out_index), 160'd0);
    chk("rst_missing", 160'(out_missing), 160'd0);
  endtask

  task automatic finish_sweep();
    chk("busy_in_done", 160'(busy), 160'd1);
    tick();
    chk("busy_after_done", 160'(busy), 160'd0);
    chk("done_pulse", 160'(done), 160'd0);
    chk("sb_drained", 160'(sb.size()), 160'd0);
  endtask

  task automatic sweep_full();
    int k, first_valid;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    first_valid = -1;
    while (done !== 1'b1 && k < 400) begin
      if (valid === 1'b1 && first_valid < 0) first_valid = k;
      tick();
      k++;
    end
    chk("first_valid_cycle", 160'(first_valid), 160'(exp_first));
    chk("done_cycle", 160'(k), 160'(exp_done));
    finish_sweep();
  endtask

  initial begin
    exp_t e0, e3;
    int   i, j;
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    edges = 0;
    for (int c = 0; c < int'(NC); c++) begin
      e0 = model(c / int'(W), c % int'(W));
      if (e0.miss != 9'd0) edges++;
    end
    e0 = model(0, 0);
    e3 = model(0, 3);
    exp_done  = 1 + 3 * int'(NC) + 2 * BB * edges;
    exp_first = 3 + 2 * BB * int'(e0.miss != 9'd0);

    @(negedge clk);
    tick();
    tick();
    chk_zero();
    rst = 1'b0;
    tick();

    // Free-running sweep.
    push(NC);
    sweep_full();

    // Backpressure at cell 2, plus a start pulse while busy.
    push(NC);
    last_pop = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    i = 0;
    while (last_pop != 1 && i < 200) begin tick(); i++; end
    ready = 1'b0;
    i = 0;
    while (valid !== 1'b1 && i < 20) begin tick(); i++; end
    for (int n = 0; n < 5; n++) begin
      chk("bp_valid", 160'(valid), 160'd1);
      chk("bp_index", 160'(out_index), 160'd2);
      chk("bp_out_f", 160'(out_f), 160'(sb[0].f));
      chk("bp_rd_addr", 160'(rd_addr), 160'(sb[0].addr));
      chk("bp_missing", 160'(out_missing), 160'(sb[0].miss));
      tick();
    end
    ready = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    j = 2;
    while (valid !== 1'b1 && j < 20) begin tick(); j++; end
    chk("release_latency", 160'(j), 160'(3 + 2 * BB * int'(e3.miss != 9'd0)));
    i = 0;
    while (done !== 1'b1 && i < 400) begin tick(); i++; end
    chk("done_seen", 160'(done), 160'd1);
    finish_sweep();

    // Reset in CAPTURE of cell 6, then a fresh sweep from cell 0.
    push(6);
    last_pop = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    i = 0;
    while (last_pop != 5 && i < 200) begin tick(); i++; end
    tick();
    rst = 1'b1;
    tick();
    chk_zero();
    chk("sb_drained_rst", 160'(sb.size()), 160'd0);
    rst = 1'b0;
    tick();
    push(NC);
    sweep_full();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
